// File: rtl/stack_burst_engine.sv
// stack_burst_engine
// Multi-word burst controller between the CPU sequencer and the single-port
// stack RAM. Moves 1..MAX_WORDS words between a packed bus (word 0 at the MSB)
// and consecutive RAM addresses, for reads or writes, with a configurable
// RAM read latency. Illegal burst lengths are rejected without touching RAM.
//
// Optional feature: define STACK_BURST_BOUNDS_EN to also reject bursts with
// base_address + words > DEPTH (evaluated without address wrap).
//
// Ports:
//   clock, reset_n     clock, asynchronous active-low reset
//   start              level request, held until done is seen
//   op_write           1 = write burst, 0 = read burst (sampled on acceptance)
//   base_address       address of word 0
//   words              burst length
//   wdata              write payload, word k at [(MAX_WORDS-k)*DATA_W-1 -: DATA_W]
//   rdata              read result, same packing as wdata
//   busy, done, error  status; error is valid while done is high
//   ram_address, ram_data, ram_wren, ram_q   single-port RAM interface
module stack_burst_engine #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MAX_WORDS   = 16,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned DEPTH       = 65536
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          op_write,
  input  logic [ADDR_W-1:0]             base_address,
  input  logic [ADDR_W-1:0]             words,
  input  logic [MAX_WORDS*DATA_W-1:0]   wdata,
  output logic [MAX_WORDS*DATA_W-1:0]   rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [ADDR_W-1:0]             ram_address,
  output logic [DATA_W-1:0]             ram_data,
  output logic                          ram_wren,
  input  logic [DATA_W-1:0]             ram_q
);

  localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned BUS_W = MAX_WORDS * DATA_W;
  localparam int unsigned SUM_W = ADDR_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(DEPTH);

`ifdef STACK_BURST_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt, idx_inc;
  logic [ADDR_W-1:0]   base_q, words_q;
  logic [DATA_W-1:0]   wbuf [MAX_WORDS];
  logic [DATA_W-1:0]   rbuf [MAX_WORDS];

  // Read tag pipe: stage i holds the slot index of the address presented
  // i+1 cycles ago; the last stage lines up with valid ram_q.
  logic                tag_v   [RAM_LATENCY];
  logic [IDX_W-1:0]    tag_idx [RAM_LATENCY];

  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                wren_nxt, busy_nxt, done_nxt, error_nxt;
  logic                accept;
  logic                last_beat;
  logic                len_bad, oob, reject;
  logic [SUM_W-1:0]    end_sum;
  logic                pipe_more;

  // Acceptance-time legality checks
  assign len_bad = (words == '0) || (words > ADDR_W'(MAX_WORDS));
  assign end_sum = {1'b0, base_address} + {1'b0, words};
  assign oob     = end_sum > DEPTH_LIM;
  assign reject  = len_bad || (BOUNDS_EN && oob);

  assign idx_inc   = idx + IDX_W'(1);
  assign last_beat = (ADDR_W'(idx) == (words_q - ADDR_W'(1)));

  // Reads still in flight after the coming edge (the last stage retires now)
  always_comb begin : drain_check
    pipe_more = 1'b0;
    for (int unsigned i = 0; i + 1 < RAM_LATENCY; i++) begin
      pipe_more = pipe_more | tag_v[i];
    end
  end

  // Present the read slots on the packed output bus
  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
    assign rdata[(MAX_WORDS-g)*DATA_W-1 -: DATA_W] = rbuf[g];
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin : fsm_next
    state_nxt = state;
    idx_nxt   = idx;
    addr_nxt  = ram_address;
    data_nxt  = ram_data;
    wren_nxt  = 1'b0;
    busy_nxt  = busy;
    done_nxt  = done;
    error_nxt = error;
    accept    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          if (reject) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            error_nxt = 1'b1;
          end else begin
            addr_nxt = base_address;
            if (op_write) begin
              state_nxt = S_WRITE;
              data_nxt  = wdata[BUS_W-1 -: DATA_W];
              wren_nxt  = 1'b1;
            end else begin
              state_nxt = S_READ;
            end
          end
        end
      end

      S_WRITE: begin
        if (last_beat) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt  = idx_inc;
          addr_nxt = base_q + ADDR_W'(idx_inc);
          data_nxt = wbuf[idx_inc];
          wren_nxt = 1'b1;
        end
      end

      S_READ: begin
        if (last_beat) begin
          state_nxt = S_DRAIN;
        end else begin
          idx_nxt  = idx_inc;
          addr_nxt = base_q + ADDR_W'(idx_inc);
        end
      end

      S_DRAIN: begin
        if (!pipe_more) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      S_DONE: begin
        if (!start) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs, burst context, read pipe and slot capture
  always_ff @(posedge clock or negedge reset_n) begin : datapath
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      idx         <= '0;
      base_q      <= '0;
      words_q     <= '0;
      for (int unsigned k = 0; k < MAX_WORDS; k++) begin
        wbuf[k] <= '0;
        rbuf[k] <= '0;
      end
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        tag_v[i]   <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      ram_address <= addr_nxt;
      ram_data    <= data_nxt;
      ram_wren    <= wren_nxt;
      idx         <= idx_nxt;

      // Every READ cycle presents exactly one address
      tag_v[0]   <= (state == S_READ);
      tag_idx[0] <= idx;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      if (tag_v[RAM_LATENCY-1]) begin
        rbuf[tag_idx[RAM_LATENCY-1]] <= ram_q;
      end

      // The pipe is empty in IDLE, so acceptance never races a capture
      if (accept) begin
        base_q  <= base_address;
        words_q <= words;
        for (int unsigned k = 0; k < MAX_WORDS; k++) begin
          wbuf[k] <= wdata[(MAX_WORDS-k)*DATA_W-1 -: DATA_W];
          rbuf[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_burst_engine.sv
// tb_stack_burst_engine
// Bench for stack_burst_engine with RAM_LATENCY=2: a latency-accurate RAM
// environment, a transaction-level reference model that predicts every output
// from the cycle count since acceptance, directed scenarios with literal
// expectations, and a randomized burst loop.
module tb_stack_burst_engine;

  localparam int unsigned LAT = 2;
  localparam int unsigned MW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned BW  = MW * DW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          op_write;
  logic [15:0]   base_address;
  logic [15:0]   words;
  logic [BW-1:0] wdata;
  logic [BW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   ram_address;
  logic [15:0]   ram_data;
  logic          ram_wren;
  logic [15:0]   ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  stack_burst_engine #(
    .DATA_W(DW), .ADDR_W(16), .MAX_WORDS(MW), .RAM_LATENCY(LAT), .DEPTH(65536)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op_write(op_write),
    .base_address(base_address), .words(words), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .error(error), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h required %h", nm, $time, got, exp);
    end
  endtask

  // RAM environment: read data appears LAT cycles after the address
  logic [15:0] mem       [65536];
  logic [15:0] model_mem [65536];
  logic [15:0] qp        [LAT];
  int          wren_cnt = 0;

  always @(posedge clock) begin
    qp[0] <= mem[ram_address];
    for (int i = 1; i < int'(LAT); i++) qp[i] <= qp[i-1];
    if (ram_wren) begin
      mem[ram_address] = ram_data;
      wren_cnt++;
    end
  end
  assign ram_q = qp[LAT-1];

  // Reference model: one accepted burst, described by its cycle offset m_t
  bit          m_active = 1'b0;
  bit          m_wr, m_err;
  int          m_t, m_dt, m_n;
  logic [15:0] m_base;
  logic [15:0] m_words [MW];
  logic [15:0] m_rvis  [MW];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_t      = 0;
      for (int k = 0; k < int'(MW); k++) m_rvis[k] = 16'h0;
    end else if (m_active) begin
      if (m_t >= m_dt && !start) begin
        m_active = 1'b0;
      end else begin
        if (m_wr && !m_err && m_t >= 1 && m_t <= m_n)
          model_mem[16'(m_base + 16'(m_t - 1))] = m_words[m_t-1];
        m_t++;
        for (int k = 0; k < int'(MW); k++)
          if (!m_wr && !m_err && k < m_n && m_t >= k + int'(LAT) + 2) m_rvis[k] = m_words[k];
      end
    end else if (start) begin
      m_active = 1'b1;
      m_t      = 1;
      m_wr     = op_write;
      m_base   = base_address;
      m_n      = int'(words);
      m_err    = (words == 16'd0) || (words > 16'd16);
`ifdef STACK_BURST_BOUNDS_EN
      if (({1'b0, base_address} + {1'b0, words}) > 17'd65536) m_err = 1'b1;
`endif
      for (int k = 0; k < int'(MW); k++) begin
        m_words[k] = op_write ? wdata[(int'(MW)-k)*16-1 -: 16] : model_mem[16'(base_address + 16'(k))];
        m_rvis[k]  = 16'h0;
      end
      m_dt = m_err ? 1 : (m_wr ? m_n + 1 : m_n + int'(LAT) + 1);
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clock) begin
    logic [BW-1:0] e_rd;
    bit            e_busy, e_done, e_wren;
    e_busy = m_active && (m_t < m_dt);
    e_done = m_active && (m_t >= m_dt);
    e_wren = m_active && m_wr && !m_err && (m_t >= 1) && (m_t <= m_n);
    for (int k = 0; k < int'(MW); k++) e_rd[(int'(MW)-k)*16-1 -: 16] = m_rvis[k];
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("error", error, e_done && m_err);
    chk("ram_wren", ram_wren, e_wren);
    chk("rdata", rdata, e_rd);
    if (m_active && !m_err && m_t >= 1 && m_t <= m_n)
      chk("ram_address", ram_address, 16'(m_base + 16'(m_t - 1)));
    if (e_wren)
      chk("ram_data", ram_data, m_words[m_t-1]);
  end

  // One burst: request, wait for done (bounded), optional hold, release
  task automatic run_burst(input bit wr, input logic [15:0] base, input logic [15:0] n,
                           input logic [BW-1:0] wd, input int hold, input bit early,
                           output int dc, output logic err_at_done);
    @(negedge clock);
    op_write = wr; base_address = base; words = n; wdata = wd; start = 1'b1;
    dc = -1;
    err_at_done = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (c == 1) begin
        op_write     = 1'($urandom);
        base_address = 16'($urandom);
        words        = 16'($urandom_range(0, 20));
        for (int j = 0; j < 8; j++) wdata[j*32 +: 32] = $urandom;
        if (early) start = 1'b0;
      end
      if (done) begin
        dc = c;
        err_at_done = error;
        break;
      end
    end
    if (dc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout at %0t: done not seen within 100 cycles", $time);
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        chk("done_held", done, 1'b1);
      end
    end
    start = 1'b0;
    @(negedge clock);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] wd;
    int            dc;
    logic          ed;
    int            w0;
    logic [15:0]   v;

    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      model_mem[i] = v;
    end
    reset_n = 1'b1; start = 1'b0; op_write = 1'b0;
    base_address = '0; words = '0; wdata = '0;
    #1 reset_n = 1'b0;
    #11;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_addr", ram_address, 16'h0);
    chk("rst_data", ram_data, 16'h0);
    #21 reset_n = 1'b1;

    // Write burst of three words
    mem[16'h13] = 16'h1234; model_mem[16'h13] = 16'h1234;
    wd = {16'hAAAA, 16'hBBBB, 16'hCCCC, 208'h0};
    run_burst(1'b1, 16'h0010, 16'd3, wd, 0, 1'b0, dc, ed);
    chk("wr_done_cycle", 32'(dc), 32'd4);
    chk("wr_mem10", mem[16'h10], 16'hAAAA);
    chk("wr_mem11", mem[16'h11], 16'hBBBB);
    chk("wr_mem12", mem[16'h12], 16'hCCCC);
    chk("wr_mem13", mem[16'h13], 16'h1234);

    // Read burst of four words
    for (int i = 0; i < 4; i++) begin
      mem[16'h20 + i] = 16'(i + 1);
      model_mem[16'h20 + i] = 16'(i + 1);
    end
    run_burst(1'b0, 16'h0020, 16'd4, '0, 0, 1'b0, dc, ed);
    chk("rd_done_cycle", 32'(dc), 32'd7);
    chk("rd_rdata", rdata, {16'd1, 16'd2, 16'd3, 16'd4, 192'h0});

    // Illegal lengths
    w0 = wren_cnt;
    run_burst(1'b1, 16'h0030, 16'd0, wd, 0, 1'b0, dc, ed);
    chk("len0_done_cycle", 32'(dc), 32'd1);
    chk("len0_error", ed, 1'b1);
    chk("len0_err_clear", error, 1'b0);
    run_burst(1'b1, 16'h0030, 16'd17, wd, 2, 1'b0, dc, ed);
    chk("len17_done_cycle", 32'(dc), 32'd1);
    chk("len17_error", ed, 1'b1);
    chk("len17_err_clear", error, 1'b0);
    chk("badlen_no_write", 32'(wren_cnt - w0), 32'd0);

    // Address wrap
    mem[16'hFFFF] = 16'h7777; model_mem[16'hFFFF] = 16'h7777;
    mem[16'h0000] = 16'h8888; model_mem[16'h0000] = 16'h8888;
    wd = {16'h1111, 16'h2222, 224'h0};
    run_burst(1'b1, 16'hFFFF, 16'd2, wd, 0, 1'b0, dc, ed);
`ifdef STACK_BURST_BOUNDS_EN
    chk("wrap_done_cycle", 32'(dc), 32'd1);
    chk("wrap_error", ed, 1'b1);
    chk("wrap_memFFFF", mem[16'hFFFF], 16'h7777);
    chk("wrap_mem0000", mem[16'h0000], 16'h8888);
`else
    chk("wrap_done_cycle", 32'(dc), 32'd3);
    chk("wrap_error", ed, 1'b0);
    chk("wrap_memFFFF", mem[16'hFFFF], 16'h1111);
    chk("wrap_mem0000", mem[16'h0000], 16'h2222);
`endif

    // Reset in the middle of an 8-word write
    mem[16'h0101] = 16'h0BAD; model_mem[16'h0101] = 16'h0BAD;
    @(negedge clock);
    op_write = 1'b1; base_address = 16'h0100; words = 16'd8;
    wdata = {16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04, 16'h5A05, 16'h5A06, 16'h5A07, 16'h5A08, 128'h0};
    start = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0; start = 1'b0;
    #1;
    chk("midrst_wren", ram_wren, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    chk("midrst_mem100", mem[16'h0100], 16'h5A01);
    chk("midrst_mem101", mem[16'h0101], 16'h0BAD);
    run_burst(1'b0, 16'h0101, 16'd1, '0, 0, 1'b0, dc, ed);
    chk("post_rst_done_cycle", 32'(dc), 32'd4);
    chk("post_rst_rdata", rdata, {16'h0BAD, 240'h0});

    // Start held for five cycles after done: exactly one burst
    w0 = wren_cnt;
    wd = {16'hCAFE, 16'hF00D, 224'h0};
    run_burst(1'b1, 16'h0200, 16'd2, wd, 5, 1'b0, dc, ed);
    chk("hold_done_cycle", 32'(dc), 32'd3);
    chk("hold_one_burst", 32'(wren_cnt - w0), 32'd2);

    // Randomized bursts
    for (int it = 0; it < 60; it++) begin
      bit          rwr, rearly;
      logic [15:0] rn, rb;
      int          r;
      rwr = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      rn = 16'd0;
      else if (r == 1) rn = 16'($urandom_range(17, 40));
      else if (r == 2) rn = 16'($urandom);
      else             rn = 16'($urandom_range(1, 16));
      if ($urandom_range(0, 3) == 0) rb = 16'hFFFF - 16'($urandom_range(0, 8));
      else                           rb = 16'($urandom);
      for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
      rearly = ($urandom_range(0, 3) == 0);
      run_burst(rwr, rb, rn, wd, $urandom_range(0, 3), rearly, dc, ed);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: simulation time limit reached", $time);
    $fatal(1, "time limit");
  end

endmodule
